// File: rtl/trace_pkg.sv
// Shared types and constants for the execution-trace capture unit.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  localparam logic [1:0] TRIG_MANUAL  = 2'd0;
  localparam logic [1:0] TRIG_INVALID = 2'd1;
  localparam logic [1:0] TRIG_ADDR    = 2'd2;
  localparam logic [1:0] TRIG_NEVER   = 2'd3;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read-before-write read port.
module trace_ram #(
  parameter  int DEPTH = 64,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  input  logic          rd_clr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; rd_clr forces zero for reset and out-of-range reads.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rdata <= {DW{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/exec_trace_buffer.sv
// Execution-trace capture: circular history of {code_addr, exr} frozen a programmable
// number of entries after a manual, invalid-instruction or address-match trigger.
module exec_trace_buffer
  import trace_pkg::*;
#(
  parameter  int ADDR_W  = 16,
  parameter  int INSTR_W = 16,
  parameter  int DEPTH   = 64,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic                      sysclk,
  input  logic                      sysreset,
  input  logic                      enable_exec,
  input  logic [ADDR_W-1:0]         code_addr,
  input  logic [INSTR_W-1:0]        exr,
  input  logic                      arm,
  input  logic [1:0]                trig_mode,
  input  logic                      trig,
  input  logic [ADDR_W-1:0]         trig_addr,
  input  logic [PW-1:0]             post_count,
  input  logic [PW-1:0]             rd_index,
  output logic [ADDR_W+INSTR_W-1:0] rd_data,
  output logic [1:0]                state,
  output logic [PW:0]               count,
  output logic [PW-1:0]             trig_pos
);

  localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

  trace_state_t  state_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic [PW-1:0] trig_ptr_r;
  logic [PW-1:0] trig_pos_r;
  logic [PW-1:0] remaining_r;
  logic          pend_r;

  logic          wr_en_s;
  logic          trig_hit_s;
  logic [PW-1:0] wr_ptr_inc_s;
  logic [PW:0]   count_inc_s;
  logic [PW-1:0] oldest_s;
  logic [PW-1:0] oldest_wr_s;
  logic [PW-1:0] rd_addr_s;
  logic          rd_hit_s;

  assign wr_en_s      = enable_exec & ~arm & ~sysreset & ((state_r == ARMED) | (state_r == POST));
  assign wr_ptr_inc_s = wr_ptr_r + PW'(1);
  assign count_inc_s  = (count_r == FULL_C) ? count_r : count_r + (PW+1)'(1);
  assign oldest_s     = (count_r == FULL_C) ? wr_ptr_r : {PW{1'b0}};
  // Oldest entry as it will be once the current write commits; keeps trig_pos aligned with count.
  assign oldest_wr_s  = (count_inc_s == FULL_C) ? wr_ptr_inc_s : {PW{1'b0}};
  assign rd_addr_s    = oldest_s + rd_index;
  assign rd_hit_s     = ({1'b0, rd_index} < count_r);

  // Trigger qualification for the entry being written this cycle.
  always_comb begin
    trig_hit_s = 1'b0;
    case (trig_mode)
      TRIG_MANUAL:  trig_hit_s = trig | pend_r;
      TRIG_INVALID: trig_hit_s = (exr == {INSTR_W{1'b1}});
      TRIG_ADDR:    trig_hit_s = (code_addr == trig_addr);
      TRIG_NEVER:   trig_hit_s = 1'b0;
      default:      trig_hit_s = 1'b0;
    endcase
  end

  // Capture FSM with write pointer, fill count and trigger bookkeeping.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {(PW+1){1'b0}};
      trig_ptr_r  <= {PW{1'b0}};
      trig_pos_r  <= {PW{1'b0}};
      remaining_r <= {PW{1'b0}};
      pend_r      <= 1'b0;
    end else if (arm) begin
      state_r     <= ARMED;
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {(PW+1){1'b0}};
      trig_ptr_r  <= {PW{1'b0}};
      trig_pos_r  <= {PW{1'b0}};
      remaining_r <= {PW{1'b0}};
      pend_r      <= 1'b0;
    end else begin
      case (state_r)
        ARMED: begin
          if (enable_exec) begin
            wr_ptr_r <= wr_ptr_inc_s;
            count_r  <= count_inc_s;
            pend_r   <= 1'b0;
            if (trig_hit_s) begin
              trig_ptr_r  <= wr_ptr_r;
              trig_pos_r  <= wr_ptr_r - oldest_wr_s;
              remaining_r <= post_count;
              state_r     <= (post_count == {PW{1'b0}}) ? DONE : POST;
            end
          end else if (trig && (trig_mode == TRIG_MANUAL)) begin
            pend_r <= 1'b1;
          end
        end
        POST: begin
          if (enable_exec) begin
            wr_ptr_r    <= wr_ptr_inc_s;
            count_r     <= count_inc_s;
            remaining_r <= remaining_r - PW'(1);
            trig_pos_r  <= trig_ptr_r - oldest_wr_s;
            if (remaining_r == PW'(1)) begin
              state_r <= DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (ADDR_W + INSTR_W)
  ) u_ram (
    .clk    (sysclk),
    .we     (wr_en_s),
    .waddr  (wr_ptr_r),
    .wdata  ({code_addr, exr}),
    .raddr  (rd_addr_s),
    .rd_clr (sysreset | ~rd_hit_s),
    .rdata  (rd_data)
  );

  assign state    = state_r;
  assign count    = count_r;
  assign trig_pos = trig_pos_r;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer: one task per scenario, inline checks.
module tb_exec_trace_buffer;

  logic        sysclk = 1'b0;
  logic        sysreset, enable_exec, arm, trig;
  logic [15:0] code_addr, exr, trig_addr;
  logic [1:0]  trig_mode;
  logic [5:0]  post_count, rd_index, trig_pos;
  logic [31:0] rd_data;
  logic [1:0]  state;
  logic [6:0]  count;

  int n_vec = 0;
  int n_err = 0;

  exec_trace_buffer dut (
    .sysclk(sysclk), .sysreset(sysreset), .enable_exec(enable_exec),
    .code_addr(code_addr), .exr(exr), .arm(arm), .trig_mode(trig_mode),
    .trig(trig), .trig_addr(trig_addr), .post_count(post_count),
    .rd_index(rd_index), .rd_data(rd_data), .state(state), .count(count),
    .trig_pos(trig_pos)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [15:0] exr_of(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] e);
    enable_exec = 1'b1; code_addr = a; exr = e;
    step();
    enable_exec = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [5:0] pc);
    trig_mode = m; post_count = pc; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    sysreset = 1'b1; step(); step(); sysreset = 1'b0;
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (trig_pos !== 6'd0) begin n_err++; $display("FAIL reset_trig_pos got %0d exp 0", trig_pos); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
  endtask

  task automatic test_linear();
    do_arm(2'd3, 6'd0);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL lin_armed got %0d exp 1", state); end
    for (int i = 0; i < 10; i++) wr(16'h0100 + 16'(i), exr_of(16'h0100 + 16'(i)));
    n_vec++; if (count !== 7'd10) begin n_err++; $display("FAIL lin_count got %0d exp 10", count); end
    rd_index = 6'd3; step();
    n_vec++; if (rd_data !== {16'h0103, 16'h1103}) begin n_err++; $display("FAIL lin_rd3 got %h exp %h", rd_data, {16'h0103, 16'h1103}); end
    rd_index = 6'd12; step();
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL lin_rd12 got %h exp 0", rd_data); end
    rd_index = 6'd0; step();
    n_vec++; if (rd_data !== {16'h0100, 16'h1100}) begin n_err++; $display("FAIL lin_rd0 got %h exp %h", rd_data, {16'h0100, 16'h1100}); end
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL lin_never got %0d exp 1", state); end
  endtask

  task automatic test_wrap();
    do_arm(2'd3, 6'd0);
    for (int i = 0; i < 70; i++) wr(16'(i), exr_of(16'(i)));
    n_vec++; if (count !== 7'd64) begin n_err++; $display("FAIL wrap_count got %0d exp 64", count); end
    rd_index = 6'd0; step();
    n_vec++; if (rd_data !== {16'd6, exr_of(16'd6)}) begin n_err++; $display("FAIL wrap_rd0 got %h exp %h", rd_data, {16'd6, exr_of(16'd6)}); end
    rd_index = 6'd63; step();
    n_vec++; if (rd_data !== {16'd69, exr_of(16'd69)}) begin n_err++; $display("FAIL wrap_rd63 got %h exp %h", rd_data, {16'd69, exr_of(16'd69)}); end
  endtask

  task automatic test_invalid();
    do_arm(2'd1, 6'd4);
    for (int i = 0; i < 19; i++) wr(16'(i), exr_of(16'(i)));
    wr(16'h0013, 16'hFFFF);
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL inv_post got %0d exp 2", state); end
    n_vec++; if (trig_pos !== 6'd19) begin n_err++; $display("FAIL inv_trig_pos got %0d exp 19", trig_pos); end
    for (int i = 0; i < 3; i++) wr(16'h0014 + 16'(i), exr_of(16'h0014 + 16'(i)));
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL inv_still_post got %0d exp 2", state); end
    wr(16'h0017, exr_of(16'h0017));
    n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL inv_done got %0d exp 3", state); end
    wr(16'h0018, exr_of(16'h0018));
    wr(16'h0019, exr_of(16'h0019));
    n_vec++; if (count !== 7'd24) begin n_err++; $display("FAIL inv_count got %0d exp 24", count); end
    n_vec++; if (trig_pos !== 6'd19) begin n_err++; $display("FAIL inv_trig_pos_done got %0d exp 19", trig_pos); end
    rd_index = 6'd19; step();
    n_vec++; if (rd_data !== {16'h0013, 16'hFFFF}) begin n_err++; $display("FAIL inv_rd19 got %h exp %h", rd_data, {16'h0013, 16'hFFFF}); end
    rd_index = 6'd23; step();
    n_vec++; if (rd_data !== {16'h0017, 16'h1017}) begin n_err++; $display("FAIL inv_rd23 got %h exp %h", rd_data, {16'h0017, 16'h1017}); end
  endtask

  task automatic test_addr_match();
    trig_addr = 16'h0040;
    do_arm(2'd2, 6'd0);
    for (int i = 0; i < 100; i++) wr(16'(i), exr_of(16'(i)));
    n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL am_done got %0d exp 3", state); end
    n_vec++; if (count !== 7'd64) begin n_err++; $display("FAIL am_count got %0d exp 64", count); end
    n_vec++; if (trig_pos !== 6'd63) begin n_err++; $display("FAIL am_trig_pos got %0d exp 63", trig_pos); end
    rd_index = 6'd63; step();
    n_vec++; if (rd_data !== {16'h0040, 16'h1040}) begin n_err++; $display("FAIL am_rd63 got %h exp %h", rd_data, {16'h0040, 16'h1040}); end
    rd_index = 6'd0; step();
    n_vec++; if (rd_data !== {16'h0001, 16'h1001}) begin n_err++; $display("FAIL am_rd0 got %h exp %h", rd_data, {16'h0001, 16'h1001}); end
  endtask

  task automatic test_manual();
    do_arm(2'd0, 6'd2);
    for (int i = 0; i < 3; i++) wr(16'(i), exr_of(16'(i)));
    trig = 1'b1; step(); trig = 1'b0;
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL man_pending_armed got %0d exp 1", state); end
    wr(16'h0003, exr_of(16'h0003));
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL man_post got %0d exp 2", state); end
    n_vec++; if (trig_pos !== 6'd3) begin n_err++; $display("FAIL man_trig_pos got %0d exp 3", trig_pos); end
    trig = 1'b1; arm = 1'b1; enable_exec = 1'b1; code_addr = 16'h0004; exr = 16'hFFFF;
    step();
    trig = 1'b0; arm = 1'b0; enable_exec = 1'b0;
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL man_rearm_state got %0d exp 1", state); end
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL man_rearm_count got %0d exp 0", count); end
    n_vec++; if (trig_pos !== 6'd0) begin n_err++; $display("FAIL man_rearm_trig_pos got %0d exp 0", trig_pos); end
    wr(16'h0005, exr_of(16'h0005));
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL man_no_pending got %0d exp 1", state); end
    n_vec++; if (count !== 7'd1) begin n_err++; $display("FAIL man_count1 got %0d exp 1", count); end
  endtask

  task automatic test_reset_mid();
    do_arm(2'd0, 6'd5);
    wr(16'h0000, exr_of(16'h0000));
    trig = 1'b1; wr(16'h0001, exr_of(16'h0001)); trig = 1'b0;
    wr(16'h0002, exr_of(16'h0002));
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL rm_post got %0d exp 2", state); end
    rd_index = 6'd0;
    sysreset = 1'b1; arm = 1'b1; enable_exec = 1'b1;
    step();
    sysreset = 1'b0; arm = 1'b0; enable_exec = 1'b0;
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL rm_state got %0d exp 0", state); end
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL rm_count got %0d exp 0", count); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL rm_rd_data got %h exp 0", rd_data); end
    wr(16'h0009, exr_of(16'h0009));
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL rm_idle_nowrite got %0d exp 0", count); end
  endtask

  initial begin
    sysreset = 1'b1; enable_exec = 1'b0; arm = 1'b0; trig = 1'b0;
    code_addr = 16'd0; exr = 16'd0; trig_addr = 16'd0;
    trig_mode = 2'd3; post_count = 6'd0; rd_index = 6'd0;
    test_reset();
    test_linear();
    test_wrap();
    test_invalid();
    test_addr_match();
    test_manual();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Synthesizable execution-trace capture unit for the supervised MCU. It records `{code_addr, exr}` for every executing instruction cycle into a circular buffer and stops a programmable number of entries after a trigger. The trigger can be manual, an invalid instruction (`exr` all ones), or an address match. The supervisor reads the frozen history through an indexed read port, moving trace checking from the simulation bench into hardware.

## Interface
- `ADDR_W`, 16, code address width.
- `INSTR_W`, 16, instruction (`exr`) width.
- `DEPTH`, 64, entry count; power of two, ≥ 4. `PW` = log2(`DEPTH`).
- `sysclk`  in  1  system clock; all logic on its rising edge.
- `sysreset`  in  1  reset, synchronous, active-high.
- `enable_exec`  in  1  executing-instruction strobe, one per retired instruction.
- `code_addr`  in  ADDR_W  address of the executing instruction.
- `exr`  in  INSTR_W  executing instruction word.
- `arm`  in  1  pulse: clear the buffer and begin capture.
- `trig_mode`  in  2  0 = manual, 1 = invalid instruction, 2 = address match, 3 = never.
- `trig`  in  1  manual trigger pulse.
- `trig_addr`  in  ADDR_W  match address for mode 2.
- `post_count`  in  PW  entries to capture after the trigger entry (0..DEPTH-1); sampled at trigger.
- `rd_index`  in  PW  read index, 0 = oldest valid entry.
- `rd_data`  out  ADDR_W+INSTR_W  `{addr, exr}` at `rd_index`; registered.
- `state`  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- `count`  out  PW+1  valid entries, saturates at `DEPTH`.
- `trig_pos`  out  PW  index of the trigger entry relative to the oldest entry.

## Operation
- States:
  - IDLE: no writes.
  - ARMED: write entries, evaluate the trigger.
  - POST: write entries, count down the remaining post-trigger entries.
  - DONE: frozen, no writes.
- `arm` from any state:
  - Next state ARMED; `wr_ptr`, `count`, `trig_pos`, pending trigger and countdown all cleared.
  - An `enable_exec` in the same cycle is not captured.
  - `arm` has priority over every trigger.
- Write (ARMED or POST with `enable_exec`): `mem[wr_ptr] <= {code_addr, exr}`; `wr_ptr` increments mod `DEPTH`; `count` increments up to `DEPTH`.
- Trigger qualification applies in ARMED on an `enable_exec` cycle only. The entry written that cycle is the trigger entry.
  - Mode 0: `trig` in this cycle, or a latched pending `trig`. A `trig` pulse with no `enable_exec` sets pending, which holds until the next write or `arm`. `trig` outside ARMED is ignored.
  - Mode 1: `exr == {INSTR_W{1'b1}}`.
  - Mode 2: `code_addr == trig_addr`.
  - Mode 3: never triggers; capture wraps indefinitely.
- On trigger:
  - Latch `trig_ptr = wr_ptr` (before increment) and `remaining = post_count`.
  - If `post_count == 0`, go to DONE; otherwise go to POST.
- POST: each write decrements `remaining`. The write that brings it to 0 is captured, then the state becomes DONE.
- Oldest entry: `oldest = (count == DEPTH) ? wr_ptr : 0`.
- Read:
  - `rd_data <= mem[(oldest + rd_index) mod DEPTH]` when `rd_index < count`; otherwise `rd_data <= 0`.
  - Reads are legal in every state.
  - A same-cycle read and write to one location returns the old contents.
- `trig_pos = (trig_ptr - oldest) mod DEPTH` in POST and DONE; 0 in IDLE and ARMED.
- Reset: `state` = IDLE, `count` = 0, `trig_pos` = 0, `rd_data` = 0, pointers and pending trigger cleared. Memory contents are unspecified but unreadable, because `count` = 0.

## Timing
- Capture: an entry is visible to reads from the cycle after its write edge.
- Read latency: 1 cycle. `rd_index` is sampled at edge N; `rd_data` is valid after edge N and reflects writes committed before edge N.
- State transitions take effect at the edge that samples the causing input. `state` reads ARMED in the cycle after `arm`.
- `count` and `trig_pos` update at the same edge as the write.
- Wrap-around: when `wr_ptr` wraps with `count == DEPTH`, the oldest entry is overwritten and `oldest` advances by one.
- A trigger entry that is later overwritten during POST is impossible, because `post_count ≤ DEPTH-1`.
- `sysreset` mid-capture forces IDLE at that edge, regardless of `arm` or `enable_exec`.

## Structure
- Package `trace_pkg`:
  - State enum `trace_state_t` (IDLE/ARMED/POST/DONE).
  - Trigger mode constants `TRIG_MANUAL`, `TRIG_INVALID`, `TRIG_ADDR`, `TRIG_NEVER`.
- Sub-module `trace_ram`: simple dual-port RAM, `DEPTH` × (ADDR_W+INSTR_W), one write port, registered read-before-write read port. The top level holds the FSM, pointers, trigger logic and index arithmetic.

## Test plan
- Reset, then `arm`, mode 3, 10 writes with addr 0x0100..0x0109 → `count` = 10; `rd_index` = 3 returns `{0x0103, exr}` one cycle later; `rd_index` = 12 returns 0.
- `DEPTH` = 64, mode 3, 70 writes with addr 0..69 → `count` = 64; `rd_index` 0 gives addr 6; `rd_index` 63 gives addr 69.
- Mode 1, `post_count` = 4, `exr` = 0xFFFF on write #20 (addr 0x0013) → state POST, then DONE after 4 more writes; `count` = 24; `trig_pos` = 19; further writes are ignored.
- Mode 2, `trig_addr` = 0x0040, `post_count` = 0, after 100 wrapping writes → DONE on the match write; `rd_index` 63 returns addr 0x0040 entry; `trig_pos` = 63.
- Mode 0, `trig` pulsed on a cycle without `enable_exec` → pending; the next write becomes the trigger entry. `arm` on the same cycle as a trigger clears everything, and the state stays ARMED.
- `sysreset` asserted in POST mid-countdown → next cycle `state` = 0, `count` = 0, `rd_data` = 0.
